// File: rtl/simmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// simmem_pkg: shared address/identifier types for the memory simulator
// Rev 1.0
// ------------------------------------------------------------------
package simmem_pkg;

    typedef logic [31:0] waddr_t;
    typedef logic [31:0] raddr_t;
    typedef logic [3:0]  write_iid_t;
    typedef logic [3:0]  read_iid_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_R = 2'd1,
        SERVE_W = 2'd2,
        TURN    = 2'd3
    } rw_sched_state_e;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_W = 1'b1
    } rw_dir_e;

endpackage
`default_nettype wire

// File: rtl/simmem_rw_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// simmem_rw_scheduler: one-direction-at-a-time R/W address gate with
// streak capping and bus-turnaround idle cycles.  Rev 1.0
// ------------------------------------------------------------------
module simmem_rw_scheduler
    import simmem_pkg::*;
#(
    parameter int TurnaroundCycles = 2,
    parameter int MaxStreak        = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  waddr_t          waddr_i,
    input  write_iid_t      waddr_iid_i,
    input  logic            waddr_valid_i,
    output logic            waddr_ready_o,
    input  raddr_t          raddr_i,
    input  read_iid_t       raddr_iid_i,
    input  logic            raddr_valid_i,
    output logic            raddr_ready_o,
    output waddr_t          core_waddr_o,
    output write_iid_t      core_waddr_iid_o,
    output logic            core_waddr_valid_o,
    input  logic            core_waddr_ready_i,
    output raddr_t          core_raddr_o,
    output read_iid_t       core_raddr_iid_o,
    output logic            core_raddr_valid_o,
    input  logic            core_raddr_ready_i,
    output rw_sched_state_e sched_state_o
);

    localparam int STREAK_W   = $clog2(MaxStreak + 1);
    localparam int TURN_CNT_W = (TurnaroundCycles > 0) ? $clog2(TurnaroundCycles + 1) : 1;
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MaxStreak);
    localparam logic [TURN_CNT_W-1:0] TURN_LOAD  =
        (TurnaroundCycles > 0) ? TURN_CNT_W'(TurnaroundCycles - 1) : '0;
    localparam bit NO_TURN = (TurnaroundCycles == 0);

    rw_sched_state_e       state_q, state_d;
    rw_dir_e               last_dir_q, last_dir_d;
    rw_dir_e               target_dir_q, target_dir_d;
    logic [STREAK_W-1:0]   streak_q, streak_d, streak_nxt;
    logic [TURN_CNT_W-1:0] turn_cnt_q, turn_cnt_d;

    logic    enter_serve;
    logic    enter_turn;
    rw_dir_e switch_dir;
    logic    fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_dir_q   <= DIR_R;
            target_dir_q <= DIR_R;
            streak_q     <= '0;
            turn_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            target_dir_q <= target_dir_d;
            streak_q     <= streak_d;
            turn_cnt_q   <= turn_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_dir_d   = last_dir_q;
        target_dir_d = target_dir_q;
        streak_d     = streak_q;
        turn_cnt_d   = turn_cnt_q;
        enter_serve  = 1'b0;
        enter_turn   = 1'b0;
        switch_dir   = DIR_R;
        fire         = 1'b0;
        streak_nxt   = streak_q;

        case (state_q)
            IDLE: begin
                if (raddr_valid_i || waddr_valid_i) begin
                    switch_dir = raddr_valid_i ? DIR_R : DIR_W;
                    if (switch_dir == last_dir_q) enter_serve = 1'b1;
                    else                          enter_turn  = 1'b1;
                end
            end
            SERVE_R: begin
                fire = raddr_valid_i && core_raddr_ready_i;
                if (fire && streak_q != STREAK_MAX) streak_nxt = streak_q + 1'b1;
                streak_d = streak_nxt;
                if (waddr_valid_i && (streak_nxt == STREAK_MAX || !raddr_valid_i)) begin
                    switch_dir = DIR_W;
                    enter_turn = 1'b1;
                end else if (!raddr_valid_i && !waddr_valid_i) begin
                    state_d = IDLE;
                end
            end
            SERVE_W: begin
                fire = waddr_valid_i && core_waddr_ready_i;
                if (fire && streak_q != STREAK_MAX) streak_nxt = streak_q + 1'b1;
                streak_d = streak_nxt;
                if (raddr_valid_i && (streak_nxt == STREAK_MAX || !waddr_valid_i)) begin
                    switch_dir = DIR_R;
                    enter_turn = 1'b1;
                end else if (!raddr_valid_i && !waddr_valid_i) begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                // The target is committed on entry; a dropped request is noticed by the serve state.
                if (turn_cnt_q == '0) begin
                    switch_dir  = target_dir_q;
                    enter_serve = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_turn && !NO_TURN) begin
            state_d      = TURN;
            target_dir_d = switch_dir;
            turn_cnt_d   = TURN_LOAD;
        end else if (enter_turn || enter_serve) begin
            state_d    = (switch_dir == DIR_R) ? SERVE_R : SERVE_W;
            last_dir_d = switch_dir;
            streak_d   = '0;
        end
    end

    always_comb begin
        core_raddr_valid_o = raddr_valid_i      && (state_q == SERVE_R);
        raddr_ready_o      = core_raddr_ready_i && (state_q == SERVE_R);
        core_waddr_valid_o = waddr_valid_i      && (state_q == SERVE_W);
        waddr_ready_o      = core_waddr_ready_i && (state_q == SERVE_W);
    end

    assign core_waddr_o     = waddr_i;
    assign core_waddr_iid_o = waddr_iid_i;
    assign core_raddr_o     = raddr_i;
    assign core_raddr_iid_o = raddr_iid_i;
    assign sched_state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_simmem_rw_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_simmem_rw_scheduler: three parameterisations against a grant-rule model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_simmem_rw_scheduler;
    import simmem_pkg::*;

    localparam int N = 3;
    localparam int TS [N] = '{2, 0, 1};
    localparam int MS [N] = '{4, 4, 2};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    waddr_t     waddr;
    write_iid_t wiid;
    logic       wv;
    raddr_t     raddr;
    read_iid_t  riid;
    logic       rv;
    logic       cwr, crr;

    logic [N-1:0]    wr, rr, cwv, crv;
    waddr_t          cwa [N];
    write_iid_t      cwi [N];
    raddr_t          cra [N];
    read_iid_t       cri [N];
    rw_sched_state_e st  [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            simmem_rw_scheduler #(
                .TurnaroundCycles(TS[g]),
                .MaxStreak       (MS[g])
            ) u_dut (
                .clk_i             (clk),
                .rst_ni            (rst_n),
                .waddr_i           (waddr),
                .waddr_iid_i       (wiid),
                .waddr_valid_i     (wv),
                .waddr_ready_o     (wr[g]),
                .raddr_i           (raddr),
                .raddr_iid_i       (riid),
                .raddr_valid_i     (rv),
                .raddr_ready_o     (rr[g]),
                .core_waddr_o      (cwa[g]),
                .core_waddr_iid_o  (cwi[g]),
                .core_waddr_valid_o(cwv[g]),
                .core_waddr_ready_i(cwr),
                .core_raddr_o      (cra[g]),
                .core_raddr_iid_o  (cri[g]),
                .core_raddr_valid_o(crv[g]),
                .core_raddr_ready_i(crr),
                .sched_state_o     (st[g])
            );
        end
    endgenerate

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Model: phase 0 = nobody owns the bus, 1 = owner 'dir' may transfer, 2 = bus
    // idle for 'left' more cycles before 'dir' takes over.
    typedef struct packed {
        int phase;
        int dir;
        int last;
        int streak;
        int left;
    } mdl_t;

    mdl_t m [N];

    function automatic mdl_t reset_m();
        mdl_t r;
        r.phase = 0; r.dir = 0; r.last = 0; r.streak = 0; r.left = 0;
        return r;
    endfunction

    function automatic mdl_t go(mdl_t s, int d, int t, logic via_turn);
        mdl_t n = s;
        if (via_turn && t > 0) begin
            n.phase = 2; n.dir = d; n.left = t;
        end else begin
            n.phase = 1; n.dir = d; n.last = d; n.streak = 0;
        end
        return n;
    endfunction

    function automatic mdl_t step(mdl_t s, int t, int mx, logic r_v, logic w_v, logic r_rdy, logic w_rdy);
        mdl_t n = s;
        logic xv, yv, xr;
        int   sk, d;
        case (s.phase)
            0: begin
                if (r_v || w_v) begin
                    d = r_v ? 0 : 1;
                    n = go(s, d, t, d != s.last);
                end
            end
            1: begin
                xv = (s.dir == 1) ? w_v : r_v;
                yv = (s.dir == 1) ? r_v : w_v;
                xr = (s.dir == 1) ? w_rdy : r_rdy;
                sk = s.streak + ((xv && xr) ? 1 : 0);
                if (sk > mx) sk = mx;
                n.streak = sk;
                if (yv && (sk == mx || !xv)) n = go(n, 1 - s.dir, t, 1'b1);
                else if (!xv && !yv)         n.phase = 0;
            end
            default: begin
                n.left = s.left - 1;
                if (n.left == 0) n = go(n, s.dir, t, 1'b0);
            end
        endcase
        return n;
    endfunction

    always @(negedge clk) begin : p_cmp
        logic e_crv, e_rr, e_cwv, e_wr;
        rw_sched_state_e e_st;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m[i] = reset_m();
                e_crv = 1'b0; e_rr = 1'b0; e_cwv = 1'b0; e_wr = 1'b0;
                e_st  = IDLE;
            end else begin
                e_crv = rv  && m[i].phase == 1 && m[i].dir == 0;
                e_rr  = crr && m[i].phase == 1 && m[i].dir == 0;
                e_cwv = wv  && m[i].phase == 1 && m[i].dir == 1;
                e_wr  = cwr && m[i].phase == 1 && m[i].dir == 1;
                e_st  = (m[i].phase == 0) ? IDLE :
                        (m[i].phase == 2) ? TURN :
                        (m[i].dir == 1)   ? SERVE_W : SERVE_R;
            end
            chk("core_raddr_valid", i, 64'(crv[i]), 64'(e_crv));
            chk("raddr_ready",      i, 64'(rr[i]),  64'(e_rr));
            chk("core_waddr_valid", i, 64'(cwv[i]), 64'(e_cwv));
            chk("waddr_ready",      i, 64'(wr[i]),  64'(e_wr));
            chk("sched_state",      i, 64'(st[i]),  64'(e_st));
            chk("core_raddr",       i, 64'(cra[i]), 64'(raddr));
            chk("core_raddr_iid",   i, 64'(cri[i]), 64'(riid));
            chk("core_waddr",       i, 64'(cwa[i]), 64'(waddr));
            chk("core_waddr_iid",   i, 64'(cwi[i]), 64'(wiid));
            if (rst_n) m[i] = step(m[i], TS[i], MS[i], rv, wv, crr, cwr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        waddr = $urandom;
        raddr = $urandom;
        wiid  = 4'($urandom);
        riid  = 4'($urandom);
    endtask

    task automatic idle_in();
        rv = 1'b0; wv = 1'b0; crr = 1'b1; cwr = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_a, first_b, n_a, n_b, n_t, ok;

        rst_n = 1'b0;
        rv = 1'b1; wv = 1'b1; crr = 1'b1; cwr = 1'b1;
        waddr = 32'h1234_5678; raddr = 32'h9abc_def0; wiid = 4'h3; riid = 4'h5;
        @(negedge clk);
        chk("reset_valids",  0, 64'({crv, cwv}), 64'd0);
        chk("reset_readies", 0, 64'({rr, wr}),   64'd0);
        chk("reset_state",   0, 64'(st[0]),      64'(IDLE));
        cyc();
        rst_n = 1'b1;
        idle_in();
        cyc();

        // Ten back-to-back reads.
        do_reset();
        rv = 1'b1; first_a = -1; n_a = 0; n_t = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (rr[0]) begin n_a++; if (first_a < 0) first_a = k; end
            if (st[0] == TURN) n_t++;
            cyc();
        end
        rv = 1'b0;
        chk("reads_first_grant", 0, 64'(first_a), 64'd1);
        chk("reads_grant_count", 0, 64'(n_a),     64'd10);
        chk("reads_turn_cycles", 0, 64'(n_t),     64'd0);

        // Write from IDLE after reset (last direction is read).
        do_reset();
        wv = 1'b1; first_a = -1; first_b = -1; n_t = 0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (wr[0] && first_a < 0) first_a = k;
            if (wr[1] && first_b < 0) first_b = k;
            if ((k == 1 || k == 2) && st[0] == TURN) n_t++;
            cyc();
        end
        chk("write_first_grant_t2", 0, 64'(first_a), 64'd3);
        chk("write_first_grant_t0", 1, 64'(first_b), 64'd1);
        chk("write_turn_cycles",    0, 64'(n_t),     64'd2);

        // Asynchronous reset while serving writes.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_core_wvalid", 0, 64'(cwv[0]), 64'd0);
        chk("midrst_state",       0, 64'(st[0]),  64'(IDLE));
        cyc();
        rst_n = 1'b1;
        wv = 1'b0;
        cyc();

        // Both directions continuously valid.
        do_reset();
        rv = 1'b1; wv = 1'b1; n_a = 0; n_b = 0; n_t = 0; first_a = 0; first_b = 0;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                if (rr[0]) n_a++;
                if (wr[0]) n_b++;
                if (st[0] == TURN) n_t++;
                if (rr[1]) first_a++;
                if (wr[1]) first_b++;
            end
            cyc();
        end
        idle_in();
        chk("both_reads_t2",  0, 64'(n_a),     64'd12);
        chk("both_writes_t2", 0, 64'(n_b),     64'd12);
        chk("both_turns_t2",  0, 64'(n_t),     64'd12);
        chk("both_reads_t0",  1, 64'(first_a), 64'd20);
        chk("both_writes_t0", 1, 64'(first_b), 64'd16);

        // Read stall, then a write arrives during the stall.
        do_reset();
        rv = 1'b1; crr = 1'b0; ok = 0; n_a = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k == 6) wv = 1'b1;
            if (k == 9) crr = 1'b1;
            @(negedge clk);
            if (k >= 1 && k <= 8 && !rr[0] && st[0] == SERVE_R) ok++;
            if (k >= 9 && k <= 12 && rr[0]) n_a++;
            if (k == 13) chk("stall_turn_after_max", 0, 64'(st[0]), 64'(TURN));
            if (k == 15) chk("stall_serve_w",        0, 64'(st[0]), 64'(SERVE_W));
            cyc();
        end
        idle_in();
        chk("stall_hold_cycles",  0, 64'(ok),  64'd8);
        chk("stall_reads_to_max", 0, 64'(n_a), 64'd4);

        // Tie in IDLE with last direction write: read wins via TURN.
        do_reset();
        wv = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k == 5) wv = 1'b0;
            if (k == 7) begin rv = 1'b1; wv = 1'b1; end
            @(negedge clk);
            if (k == 7)  chk("tie_idle",    0, 64'(st[0]), 64'(IDLE));
            if (k == 8)  chk("tie_turn",    0, 64'(st[0]), 64'(TURN));
            if (k == 10) chk("tie_serve_r", 0, 64'(st[0]), 64'(SERVE_R));
            if (k == 10) chk("tie_r_grant", 0, 64'(rr[0]), 64'd1);
            cyc();
        end
        idle_in();

        // Randomised traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rv    = ($urandom_range(0, 99) < 65);
            wv    = ($urandom_range(0, 99) < 65);
            crr   = ($urandom_range(0, 99) < 80);
            cwr   = ($urandom_range(0, 99) < 80);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst_n = 1'b1;
        idle_in();
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
